// File: rtl/twoask_demod.sv
// 2ASK receive path: rectify, integrate-and-dump each bit period, threshold the
// energy into a bit, then check the recovered stream against the PN7 m-sequence.
module twoask_demod #(
  parameter int OFFSET    = 128,
  parameter int SPB       = 32,
  parameter int DET_LVL   = 48,
  parameter int THRESH    = 1024,
  parameter int LOSS_BITS = 16,
  parameter int ACC_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_en,
  input  logic [7:0]  adc_data,
  output logic        bit_out,
  output logic        bit_valid,
  output logic        locked,
  output logic        pn_sync,
  output logic [15:0] err_cnt,
  output logic        state_dbg
);

  // sample_en is a one-cycle valid with no ready: every strobed sample is consumed,
  // and bit_valid is a one-cycle valid that downstream must accept when it fires.

  localparam int CNT_W = $clog2(SPB);
  localparam int ZR_W  = $clog2(LOSS_BITS + 1);
  localparam logic [8:0] OFF9 = 9'(OFFSET);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_TRACK  = 1'b1
  } state_t;

  state_t state, state_nx;

  // ---------------- stage 1: rectifier ----------------
  logic [8:0] diff;
  logic [6:0] rect_d, rect_q;
  logic       rect_v;

  always_comb begin
    diff = '0;
    if ({1'b0, adc_data} >= OFF9) diff = {1'b0, adc_data} - OFF9;
    else                          diff = OFF9 - {1'b0, adc_data};
    rect_d = (diff > 9'd127) ? 7'd127 : diff[6:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rect_q <= '0;
      rect_v <= 1'b0;
    end else begin
      rect_v <= sample_en;
      if (sample_en) rect_q <= rect_d;
    end
  end

  // ---------------- acquisition / integrate-and-dump FSM ----------------
  logic [ACC_W-1:0] acc, acc_nx, acc_sum;
  logic [CNT_W-1:0] samp_cnt, samp_nx;
  logic [ZR_W-1:0]  zero_run, zrun_nx;
  logic             dec_fire, dec_bit, loss;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_SEARCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    samp_nx  = samp_cnt;
    zrun_nx  = zero_run;
    dec_fire = 1'b0;
    dec_bit  = 1'b0;
    loss     = 1'b0;
    acc_sum  = acc + ACC_W'(rect_q);
    if (rect_v) begin
      case (state)
        ST_SEARCH: begin
          // The detecting sample is sample 0 of the first bit.
          if (rect_q >= 7'(DET_LVL)) begin
            state_nx = ST_TRACK;
            acc_nx   = ACC_W'(rect_q);
            samp_nx  = CNT_W'(1);
          end
        end
        ST_TRACK: begin
          if (samp_cnt == CNT_W'(SPB - 1)) begin
            dec_fire = 1'b1;
            dec_bit  = (acc_sum >= ACC_W'(THRESH));
            acc_nx   = '0;
            samp_nx  = '0;
            if (dec_bit) begin
              zrun_nx = '0;
            end else if (zero_run == ZR_W'(LOSS_BITS - 1)) begin
              // Longer zero run than PN7 can produce: the carrier is gone.
              loss     = 1'b1;
              zrun_nx  = '0;
              state_nx = ST_SEARCH;
            end else begin
              zrun_nx = zero_run + ZR_W'(1);
            end
          end else begin
            acc_nx  = acc_sum;
            samp_nx = samp_cnt + CNT_W'(1);
          end
        end
        default: state_nx = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      samp_cnt  <= '0;
      zero_run  <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      locked    <= 1'b0;
    end else begin
      acc       <= acc_nx;
      samp_cnt  <= samp_nx;
      zero_run  <= zrun_nx;
      bit_valid <= dec_fire;
      locked    <= (state == ST_TRACK);
      if (dec_fire) bit_out <= dec_bit;
    end
  end

  assign state_dbg = state;

  // ---------------- PN7 checker, x^7 + x^6 + 1 ----------------
  logic [6:0]  hist;
  logic [2:0]  fill;
  logic [3:0]  match_run, mr_inc;
  logic [15:0] err_q;
  logic        pred, mism;

  always_comb begin
    pred   = hist[6] ^ hist[5];
    mism   = (fill == 3'd7) && (dec_bit != pred);
    mr_inc = (match_run == 4'd15) ? match_run : match_run + 4'd1;
  end

  // The checker consumes the decision on the same edge that publishes bit_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= '0;
      fill      <= '0;
      match_run <= '0;
      pn_sync   <= 1'b0;
      err_q     <= '0;
    end else if (dec_fire) begin
      if (loss) begin
        hist      <= '0;
        fill      <= '0;
        match_run <= '0;
        pn_sync   <= 1'b0;
      end else begin
        hist <= {hist[5:0], dec_bit};
        if (fill != 3'd7) fill <= fill + 3'd1;
        if (fill == 3'd7) begin
          if (mism) begin
            if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
            match_run <= '0;
            pn_sync   <= 1'b0;
          end else begin
            match_run <= mr_inc;
            if (mr_inc >= 4'd14) pn_sync <= 1'b1;
          end
        end
      end
    end
  end

  assign err_cnt = err_q;

endmodule

// File: tb/tb_twoask_demod.sv
// Bench for twoask_demod: drives modulated 2ASK samples and checks recovered bits,
// bit timing, lock behaviour and PN7 checker results against its own expectations.
module tb_twoask_demod;

  localparam int SPB = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_en;
  logic [7:0]  adc_data;
  logic        bit_out;
  logic        bit_valid;
  logic        locked;
  logic        pn_sync;
  logic [15:0] err_cnt;
  logic        state_dbg;

  twoask_demod #(.SPB(SPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .adc_data  (adc_data),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .locked    (locked),
    .pn_sync   (pn_sync),
    .err_cnt   (err_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic [0:0] exp_q[$];
  int         lat_q[$];
  logic       sync_at [0:511];
  logic [15:0] err_at [0:511];
  int         bv_idx = 0;
  bit         gaps, noise, carr;
  logic       pn [0:511];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_en = 1'b0;
    idle(3);
    rst = 1'b0;
    carr = 1'b0;
  endtask

  // ---------------- drivers ----------------
  task automatic put_sample(input logic [7:0] d, input bit last);
    sample_en = 1'b1;
    adc_data  = d;
    @(posedge clk); #1;
    if (last) lat_q.push_back(cyc);
    sample_en = 1'b0;
    adc_data  = 8'($urandom_range(0, 255));
    if (gaps) idle($urandom_range(0, 1));
  endtask

  task automatic send_bit(input bit b, input bit suppress);
    logic rx;
    rx = b & ~suppress;
    exp_q.push_back(rx);
    for (int i = 0; i < SPB; i++) begin
      logic [7:0] d;
      int r;
      r = noise ? int'($urandom_range(0, 20)) : 0;
      if (rx) d = carr ? 8'(255 - r) : 8'(r);
      else    d = noise ? 8'(118 + r) : 8'd128;
      carr = ~carr;
      put_sample(d, i == SPB - 1);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      lat_q.delete();
      bv_idx = 0;
    end else if (bit_valid) begin
      logic [0:0] e;
      int t;
      if (exp_q.size() == 0) begin
        check("bv_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("bit_out", bit_out, e);
      end
      if (lat_q.size() != 0) begin
        t = lat_q.pop_front();
        check("latency", cyc, t + 1);
      end
      if (bv_idx < 512) begin
        sync_at[bv_idx] = pn_sync;
        err_at[bv_idx]  = err_cnt;
      end
      bv_idx++;
    end
  end

  initial begin
    #5ms;
    check("watchdog", 1, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // ---------------- tests ----------------
  initial begin
    int f;
    int drops;
    rst = 1'b1;
    sample_en = 1'b0;
    adc_data = 8'd0;
    gaps = 1'b0;
    noise = 1'b0;
    carr = 1'b0;

    pn[0] = 1'b1;
    for (int k = 1; k < 7; k++) pn[k] = 1'b0;
    for (int k = 7; k < 512; k++) pn[k] = pn[k-7] ^ pn[k-6];

    // 1: reset with random inputs
    for (int i = 0; i < 3; i++) begin
      sample_en = 1'($urandom_range(0, 1));
      adc_data  = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      check("rst_outs", {bit_out, bit_valid, locked, pn_sync, err_cnt}, 0);
    end
    sample_en = 1'b0;
    rst = 1'b0;

    // 2: mid-scale only, never acquires
    for (int i = 0; i < 1000; i++) put_sample(8'd128, 1'b0);
    idle(4);
    check("t2_locked", locked, 0);
    check("t2_bits", bv_idx, 0);

    // 3: one carrier bit, then silence until lock loss
    do_reset();
    exp_q.push_back(1'b1);
    for (int i = 0; i < SPB; i++) begin
      put_sample((i % 2 == 0) ? 8'd0 : 8'd255, i == SPB - 1);
      if (i == 0) check("t3_lock_s0", locked, 0);
      if (i == 1) check("t3_lock_s1", locked, 0);
      if (i == 2) check("t3_lock_s2", locked, 1);
    end
    for (int b = 0; b < 15; b++) send_bit(1'b0, 1'b0);
    exp_q.push_back(1'b0);
    for (int i = 0; i < SPB; i++) put_sample(8'd128, i == SPB - 1);
    @(posedge clk); #1;
    check("t3_last_bv", bit_valid, 1);
    check("t3_last_lock", locked, 1);
    check("t3_search", state_dbg, 0);
    @(posedge clk); #1;
    check("t3_lock_drop", locked, 0);
    check("t3_bv_pulse", bit_valid, 0);
    for (int i = 0; i < 200; i++) put_sample(8'd128, 1'b0);
    idle(4);
    check("t3_bits", bv_idx, 17);
    check("t3_q_empty", exp_q.size(), 0);

    // 4: three PN7 periods with gaps and noise
    do_reset();
    gaps = 1'b1;
    noise = 1'b1;
    for (int k = 0; k < 381; k++) send_bit(pn[k], 1'b0);
    idle(5);
    check("t4_bits", bv_idx, 381);
    check("t4_q_empty", exp_q.size(), 0);
    check("t4_sync20", sync_at[19], 0);
    check("t4_sync21", sync_at[20], 1);
    drops = 0;
    for (int k = 20; k < 381; k++) if (sync_at[k] !== 1'b1) drops++;
    check("t4_sync_hold", drops, 0);
    check("t4_err", err_at[380], 0);
    check("t4_locked", locked, 1);

    // 5: one suppressed mark bit
    do_reset();
    f = 0;
    for (int k = 40; k < 127; k++) if (pn[k] && f == 0) f = k;
    for (int k = 0; k <= f + 40; k++) send_bit(pn[k], k == f);
    idle(5);
    check("t5_q_empty", exp_q.size(), 0);
    check("t5_err_pre", err_at[f-1], 0);
    check("t5_sync_pre", sync_at[f-1], 1);
    check("t5_sync_drop", sync_at[f], 0);
    check("t5_err_slot", err_at[f], 1);
    check("t5_err_taps", err_at[f+7], 3);
    check("t5_sync_wait", sync_at[f+20], 0);
    check("t5_sync_back", sync_at[f+21], 1);
    check("t5_err_end", err_at[f+40], 3);

    // 6: err_cnt saturation, then reset mid-bit
    do_reset();
    for (int k = 0; k < 10; k++) send_bit(1'b1, 1'b0);
    idle(4);
    check("t6_err_ones", err_at[9], 3);
    @(negedge clk);
    dut.err_q <= 16'hFFFC;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) send_bit(1'b1, 1'b0);
    idle(4);
    check("t6_err_fffd", err_at[10], 16'hFFFD);
    check("t6_err_fffe", err_at[11], 16'hFFFE);
    check("t6_err_ffff", err_at[12], 16'hFFFF);
    check("t6_err_hold1", err_at[13], 16'hFFFF);
    check("t6_err_hold2", err_at[14], 16'hFFFF);
    for (int i = 0; i < SPB / 2; i++) begin
      put_sample(carr ? 8'd255 : 8'd0, 1'b0);
      carr = ~carr;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_bit_out", bit_out, 0);
    check("t6_rst_bit_valid", bit_valid, 0);
    check("t6_rst_locked", locked, 0);
    check("t6_rst_pn_sync", pn_sync, 0);
    check("t6_rst_err_cnt", err_cnt, 0);
    check("t6_rst_state", state_dbg, 0);
    idle(2);
    rst = 1'b0;
    idle(3);
    check("t6_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
